// File: rtl/stack_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// stack_access_arbiter_if : request/response channel of the stack arbiter
// Rev 1.0
// ============================================================================
interface stack_access_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_op;
  logic [2*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [2:0]        rsp_id;
  logic [1:0]        rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_op, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/stack_access_arbiter.sv
`default_nettype none
// ============================================================================
// stack_access_arbiter : round-robin sharing of one 2-bit x DEPTH LIFO stack
// Rev 1.0
// ============================================================================
module stack_access_arbiter #(
  parameter int NREQ  = 2,
  parameter int DEPTH = 256,
  parameter int CW    = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  stack_access_arbiter_if.slave bus,
  output logic                 stk_push,
  output logic                 stk_pop,
  output logic [1:0]           stk_din,
  input  logic                 stk_full,
  input  logic                 stk_empty,
  input  logic [1:0]           stk_top,
  output logic [CW-1:0]        occupancy
);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_issue  = 2'd1;
  localparam logic [1:0] c_st_settle = 2'd2;
  localparam logic [1:0] c_st_resp   = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;

  logic [2:0]    r_last_grant;
  logic [2:0]    r_id;
  logic          r_op;
  logic [1:0]    r_data;
  logic [2:0]    r_rsp_id;
  logic [1:0]    r_rsp_data;
  logic          r_rsp_err;
  logic [CW-1:0] r_occ;

  logic          w_found;
  logic [2:0]    w_winner;
  logic          w_sel_op;
  logic [1:0]    w_sel_data;
  int            w_best;
  int            w_dist;
  logic          w_illegal;

  // Rank each requester by its distance past the last grant; the nearest wins.
  always_comb begin
    w_found    = 1'b0;
    w_winner   = '0;
    w_sel_op   = 1'b0;
    w_sel_data = '0;
    w_best     = NREQ;
    w_dist     = 0;
    for (int j = 0; j < NREQ; j++) begin
      w_dist = (j + 2*NREQ - 1 - int'(r_last_grant)) % NREQ;
      if (bus.req_valid[j] && (w_dist < w_best)) begin
        w_best     = w_dist;
        w_found    = 1'b1;
        w_winner   = 3'(j);
        w_sel_op   = bus.req_op[j];
        w_sel_data = bus.req_data[2*j +: 2];
      end
    end
  end

  // The occupancy counter guards the stack even if its flags disagree.
  always_comb begin
    if (r_op) begin
      w_illegal = (r_occ == '0) || stk_empty;
    end else begin
      w_illegal = (r_occ == CW'(DEPTH)) || stk_full;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_found) begin
          w_next_state = c_st_issue;
        end
      end
      c_st_issue: begin
        w_next_state = w_illegal ? c_st_resp : c_st_settle;
      end
      c_st_settle: begin
        w_next_state = c_st_resp;
      end
      c_st_resp: begin
        if (bus.rsp_ready) begin
          w_next_state = c_st_idle;
        end
      end
      default: begin
        w_next_state = c_st_idle;
      end
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = 1'b0;
    stk_push      = 1'b0;
    stk_pop       = 1'b0;
    stk_din       = '0;
    case (r_state)
      c_st_idle: begin
        if (w_found) begin
          for (int j = 0; j < NREQ; j++) begin
            bus.req_ready[j] = (w_winner == 3'(j));
          end
        end
      end
      c_st_issue: begin
        if (!w_illegal) begin
          if (r_op) begin
            stk_pop = 1'b1;
          end else begin
            stk_push = 1'b1;
            stk_din  = r_data;
          end
        end
      end
      c_st_resp: begin
        bus.rsp_valid = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_grant <= 3'(NREQ - 1);
      r_id         <= '0;
      r_op         <= 1'b0;
      r_data       <= '0;
      r_rsp_id     <= '0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
      r_occ        <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_found) begin
            r_id         <= w_winner;
            r_op         <= w_sel_op;
            r_data       <= w_sel_data;
            r_last_grant <= w_winner;
          end
        end
        c_st_issue: begin
          r_rsp_id <= r_id;
          if (w_illegal) begin
            r_rsp_err <= 1'b1;
          end else if (r_op) begin
            // Top still shows the entry being popped during this cycle.
            r_rsp_data <= stk_top;
            r_occ      <= r_occ - CW'(1);
          end else begin
            r_occ <= r_occ + CW'(1);
          end
        end
        c_st_resp: begin
          if (bus.rsp_ready) begin
            r_rsp_id   <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.rsp_id   = r_rsp_id;
  assign bus.rsp_data = r_rsp_data;
  assign bus.rsp_err  = r_rsp_err;
  assign occupancy    = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_stack_access_arbiter.sv
`default_nettype none
// ============================================================================
// tb_stack_access_arbiter : scoreboard bench with a behavioural LIFO stack
// Rev 1.0
// ============================================================================
module tb_stack_access_arbiter;
  localparam int NREQ  = 2;
  localparam int DEPTH = 256;
  localparam int CW    = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          stk_push, stk_pop;
  logic [1:0]    stk_din;
  logic          sfull, sempty;
  logic [1:0]    stop;
  logic [CW-1:0] occupancy;

  stack_access_arbiter_if #(.NREQ(NREQ)) bus ();

  stack_access_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_din   (stk_din),
    .stk_full  (sfull),
    .stk_empty (sempty),
    .stk_top   (stop),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  // Stack with registered Full/Empty/Top, reset by the same system reset.
  logic [1:0] smem [0:DEPTH-1];
  int         sp;
  always @(posedge clk) begin
    if (!rst) begin
      sp <= 0; sfull <= 1'b0; sempty <= 1'b1; stop <= 2'b00;
    end else if (stk_push && sp < DEPTH) begin
      smem[sp] <= stk_din; sp <= sp + 1;
      sfull <= (sp + 1 == DEPTH); sempty <= 1'b0; stop <= stk_din;
    end else if (stk_pop && sp > 0) begin
      sp <= sp - 1; sfull <= 1'b0; sempty <= (sp == 1);
      stop <= (sp >= 2) ? smem[sp-2] : 2'b00;
    end
  end

  typedef struct {
    int         id;
    logic [1:0] data;
    bit         err;
  } rsp_t;

  rsp_t       sb[$];
  logic [1:0] exp_stk[$];
  int         tb_last;
  int         n_checks = 0;
  int         n_fail   = 0;
  rsp_t       mon_e;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference behaviour: decide the outcome of an accepted op and queue its response.
  task automatic sb_expect(input int id, input bit op, input logic [1:0] d, output bit err);
    rsp_t e;
    e.id = id; e.data = 2'b00;
    if (!op) begin
      err = (exp_stk.size() >= DEPTH);
      if (!err) exp_stk.push_back(d);
    end else begin
      err = (exp_stk.size() == 0);
      if (!err) e.data = exp_stk.pop_back();
    end
    e.err = err;
    sb.push_back(e);
    tb_last = id;
  endtask

  task automatic wait_grant(output bit ok);
    int n = 0;
    @(negedge clk);
    while (bus.req_ready == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.req_ready != '0);
    if (!ok) check_val("grant_timeout", 0, 1);
  endtask

  // One request with rsp_ready high; checks accept, strobe and response latency.
  task automatic do_op(input int id, input bit op, input logic [1:0] d);
    bit ok, err;
    logic [NREQ-1:0] oh;
    @(posedge clk); #1;
    bus.req_valid[id] = 1'b1;
    bus.req_op[id]    = op;
    bus.req_data[2*id +: 2] = d;
    wait_grant(ok);
    if (!ok) begin
      bus.req_valid[id] = 1'b0;
      return;
    end
    oh = '0; oh[id] = 1'b1;
    check_val("accept_onehot", bus.req_ready, oh);
    sb_expect(id, op, d, err);
    @(posedge clk); #1;
    bus.req_valid[id] = 1'b0;
    @(negedge clk);
    check_val("push_strobe", stk_push, (!op && !err));
    check_val("pop_strobe", stk_pop, (op && !err));
    if (!op && !err) check_val("stk_din", stk_din, d);
    @(negedge clk);
    check_val("rsp_valid_c2", bus.rsp_valid, err);
    @(negedge clk);
    check_val("rsp_valid_c3", bus.rsp_valid, !err);
    check_val("occupancy", occupancy, exp_stk.size());
  endtask

  always @(negedge clk) begin
    if (rst && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        check_val("unexpected_rsp", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check_val("rsp_id", bus.rsp_id, mon_e.id);
        check_val("rsp_data", bus.rsp_data, mon_e.data);
        check_val("rsp_err", bus.rsp_err, mon_e.err);
      end
    end
    if (rst && (stk_push || stk_pop)) check_val("strobe_excl", stk_push && stk_pop, 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, err;
    int n, w;
    logic [NREQ-1:0] oh;

    rst = 1'b0;
    bus.req_valid = '0; bus.req_op = '0; bus.req_data = '0; bus.rsp_ready = 1'b1;
    tb_last = NREQ - 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_req_ready", bus.req_ready, 0);
    check_val("rst_rsp_valid", bus.rsp_valid, 0);
    check_val("rst_strobes", {stk_push, stk_pop, stk_din}, 0);
    check_val("rst_occupancy", occupancy, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Single push, then drain it; push/push/pop/pop ordering; pop when empty.
    do_op(0, 1'b0, 2'b10);
    do_op(0, 1'b1, 2'b00);
    do_op(0, 1'b0, 2'b01);
    do_op(0, 1'b0, 2'b11);
    do_op(0, 1'b1, 2'b00);
    do_op(0, 1'b1, 2'b00);
    check_val("empty_flag", sempty, 1);
    do_op(0, 1'b1, 2'b00);

    // Both requesters pending continuously: grants must alternate.
    @(posedge clk); #1;
    bus.req_op = '0;
    bus.req_data = {2'b10, 2'b01};
    bus.req_valid = '1;
    for (int g = 0; g < 4; g++) begin
      wait_grant(ok);
      if (!ok) break;
      w = (tb_last + 1) % NREQ;
      oh = '0; oh[w] = 1'b1;
      check_val("rr_grant", bus.req_ready, oh);
      sb_expect(w, 1'b0, bus.req_data[2*w +: 2], err);
      @(posedge clk); #1;
      bus.req_data[2*w +: 2] = bus.req_data[2*w +: 2] + 2'b01;
      if (g == 3) bus.req_valid = '0;
    end
    bus.req_valid = '0;
    repeat (6) @(negedge clk);
    check_val("occ_after_rr", occupancy, exp_stk.size());

    // Stall the response channel with another requester waiting.
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid[1] = 1'b1; bus.req_op[1] = 1'b1;
    wait_grant(ok);
    check_val("stall_grant", bus.req_ready, 2'b10);
    sb_expect(1, 1'b1, 2'b00, err);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    bus.req_valid[0] = 1'b1; bus.req_op[0] = 1'b0; bus.req_data[1:0] = 2'b11;
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      check_val("hold_valid", bus.rsp_valid, 1);
      check_val("hold_id", bus.rsp_id, 1);
      check_val("hold_data", bus.rsp_data, sb[0].data);
      check_val("hold_no_ready", bus.req_ready, 0);
      check_val("hold_no_strobe", {stk_push, stk_pop}, 0);
      if (k < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("grant_after_release", bus.req_ready, 2'b01);
    sb_expect(0, 1'b0, 2'b11, err);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    repeat (4) @(negedge clk);

    // Fill to capacity, reject one more push, then pop one.
    n = 0;
    while (exp_stk.size() < DEPTH && n < 2*DEPTH) begin
      do_op(n % NREQ, 1'b0, 2'(n));
      n++;
    end
    check_val("full_flag", sfull, 1);
    do_op(0, 1'b0, 2'b01);
    do_op(1, 1'b1, 2'b00);

    // Reset while the op is in SETTLE: abandoned, no response.
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b1; bus.req_op[0] = 1'b0; bus.req_data[1:0] = 2'b01;
    wait_grant(ok);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("mid_rst_req_ready", bus.req_ready, 0);
    check_val("mid_rst_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err}, 0);
    check_val("mid_rst_strobes", {stk_push, stk_pop, stk_din}, 0);
    check_val("mid_rst_occupancy", occupancy, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_stk.delete();
    tb_last = NREQ - 1;
    repeat (5) @(negedge clk);
    do_op(1, 1'b1, 2'b00);
    do_op(0, 1'b0, 2'b10);
    repeat (3) @(negedge clk);
    check_val("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
